// File: rtl/tx_scrambler_16_if.sv
// Symbol-pair bus between the TX framing mux, the scrambler and the 8b/10b encoder.
// The master drives the input pair and observes the registered scrambled pair.
interface tx_scrambler_16_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_k;
    logic        scramble_disable;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_k;

    modport master (
        output in_valid,
        output in_data,
        output in_k,
        output scramble_disable,
        input  out_valid,
        input  out_data,
        input  out_k
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_k,
        input  scramble_disable,
        output out_valid,
        output out_data,
        output out_k
    );
endinterface

// File: rtl/tx_scrambler_16.sv
// Gen1/Gen2 PCIe TX scrambler, two symbols per pclk, G(X)=X^16+X^5+X^4+X^3+1.
// COM reseeds and SKP holds the LFSR per symbol; output pair is registered.
module tx_scrambler_16 (
    input  logic                    pclk,
    input  logic                    reset_n,
    tx_scrambler_16_if.slave        bus
);

    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [15:0] LFSR_TAPS = 16'h0039;
    localparam logic [7:0]  SYM_COM   = 8'hBC;
    localparam logic [7:0]  SYM_SKP   = 8'h1C;

    // Eight serial steps; scramble bit i is taken from lfsr[15] before step i.
    function automatic logic [15:0] lfsr_byte_step(input logic [15:0] s);
        logic [15:0] v;
        v = s;
        for (int unsigned i = 0; i < 8; i++) begin
            v = {v[14:0], 1'b0} ^ (v[15] ? LFSR_TAPS : 16'h0000);
        end
        return v;
    endfunction

    function automatic logic [7:0] lfsr_byte_mask(input logic [15:0] s);
        logic [15:0] v;
        logic [7:0]  m;
        v = s;
        m = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            m[i] = v[15];
            v    = {v[14:0], 1'b0} ^ (v[15] ? LFSR_TAPS : 16'h0000);
        end
        return m;
    endfunction

    logic [15:0] r_lfsr;
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic [1:0]  r_out_k;

    logic [7:0]  w_sym0;
    logic [7:0]  w_sym1;
    logic        w_com0;
    logic        w_com1;
    logic        w_skp0;
    logic        w_skp1;
    logic [7:0]  w_mask0;
    logic [7:0]  w_mask1;
    logic [15:0] w_step0;
    logic [15:0] w_step1;
    logic [15:0] w_lfsr_mid;
    logic [15:0] w_lfsr_end;
    logic [7:0]  w_out0;
    logic [7:0]  w_out1;

    assign w_sym0 = bus.in_data[7:0];
    assign w_sym1 = bus.in_data[15:8];
    assign w_com0 = bus.in_k[0] && (w_sym0 == SYM_COM);
    assign w_com1 = bus.in_k[1] && (w_sym1 == SYM_COM);
    assign w_skp0 = bus.in_k[0] && (w_sym0 == SYM_SKP);
    assign w_skp1 = bus.in_k[1] && (w_sym1 == SYM_SKP);

    // Symbol 0 against the registered state.
    assign w_mask0 = lfsr_byte_mask(r_lfsr);
    assign w_step0 = lfsr_byte_step(r_lfsr);

    always_comb begin
        w_lfsr_mid = w_step0;
        if (w_com0) begin
            w_lfsr_mid = LFSR_SEED;
        end else if (w_skp0) begin
            w_lfsr_mid = r_lfsr;
        end
    end

    always_comb begin
        w_out0 = w_sym0;
        if (!bus.in_k[0] && !bus.scramble_disable) begin
            w_out0 = w_sym0 ^ w_mask0;
        end
    end

    // Symbol 1 chained from symbol 0's resulting state within the same cycle.
    assign w_mask1 = lfsr_byte_mask(w_lfsr_mid);
    assign w_step1 = lfsr_byte_step(w_lfsr_mid);

    always_comb begin
        w_lfsr_end = w_step1;
        if (w_com1) begin
            w_lfsr_end = LFSR_SEED;
        end else if (w_skp1) begin
            w_lfsr_end = w_lfsr_mid;
        end
    end

    always_comb begin
        w_out1 = w_sym1;
        if (!bus.in_k[1] && !bus.scramble_disable) begin
            w_out1 = w_sym1 ^ w_mask1;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr      <= LFSR_SEED;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_k     <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_lfsr     <= w_lfsr_end;
                r_out_data <= {w_out1, w_out0};
                r_out_k    <= bus.in_k;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_k     = r_out_k;

endmodule

// File: tb/tb_tx_scrambler_16.sv
// Scoreboard bench for tx_scrambler_16: stimulus pushes expected pairs, a monitor pops
// and compares; the reference tracks a position into a precomputed keystream.
module tb_tx_scrambler_16;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
    } exp_t;

    logic pclk = 1'b0;
    logic reset_n = 1'b1;
    always #5 pclk = ~pclk;

    tx_scrambler_16_if bus ();

    tx_scrambler_16 dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0]  ks [4096];
    int          pos;
    exp_t        q [$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] last_d = '0;
    logic [1:0]  last_k = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Keystream from seed FFFF by polynomial reduction, one bit per shift, LSB first.
    task automatic build_keystream();
        int s;
        s = 'hFFFF;
        for (int b = 0; b < 4096; b++) begin
            for (int i = 0; i < 8; i++) begin
                ks[b][i] = s[15];
                s = s << 1;
                if ((s & 'h10000) != 0) s = s ^ 'h10039;
            end
        end
    endtask

    function automatic logic [7:0] model_sym(input logic [7:0] d, input logic k, input logic dis);
        logic [7:0] r;
        if (k && d == 8'hBC) begin
            pos = 0;
            return d;
        end
        if (k && d == 8'h1C) return d;
        if (k) begin
            pos++;
            return d;
        end
        r = dis ? d : (d ^ ks[pos]);
        pos++;
        return r;
    endfunction

    task automatic issue(input logic [15:0] d, input logic [1:0] k, input logic dis,
                         input logic use_const, input logic [15:0] cexp);
        exp_t e;
        logic [7:0] lo, hi;
        @(posedge pclk);
        #1;
        bus.in_valid         = 1'b1;
        bus.in_data          = d;
        bus.in_k             = k;
        bus.scramble_disable = dis;
        lo = model_sym(d[7:0], k[0], dis);
        hi = model_sym(d[15:8], k[1], dis);
        e.d = use_const ? cexp : {hi, lo};
        e.k = k;
        q.push_back(e);
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic dis);
        issue(d, k, dis, 1'b0, 16'h0000);
    endtask

    task automatic send_exp(input logic [15:0] d, input logic [1:0] k, input logic dis,
                            input logic [15:0] e);
        issue(d, k, dis, 1'b1, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            bus.in_valid         = 1'b0;
            bus.in_data          = 16'($urandom);
            bus.in_k             = 2'($urandom);
            bus.scramble_disable = 1'($urandom);
        end
    endtask

    task automatic rand_sym(output logic [7:0] d, output logic k);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 8) begin
            d = 8'hBC; k = 1'b1;
        end else if (r < 18) begin
            d = 8'h1C; k = 1'b1;
        end else if (r < 26) begin
            d = 8'($urandom); k = 1'b1;
            if (d == 8'hBC || d == 8'h1C) d = 8'hF7;
        end else begin
            d = 8'($urandom); k = 1'b0;
        end
    endtask

    // Monitor: compare on every valid output, check hold on every idle output.
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (!reset_n) begin
                last_d = '0;
                last_k = '0;
            end else if (bus.out_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got %h with no expected pair", bus.out_data);
                end else begin
                    e = q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e.d));
                    check("out_k", 32'(bus.out_k), 32'(e.k));
                    last_d = e.d;
                    last_k = e.k;
                end
            end else begin
                check("hold_data", 32'(bus.out_data), 32'(last_d));
                check("hold_k", 32'(bus.out_k), 32'(last_k));
            end
        end
    end

    initial begin
        logic [7:0] d0, d1;
        logic       k0, k1;

        build_keystream();
        pos = 0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_k = '0;
        bus.scramble_disable = 1'b0;

        #1 reset_n = 1'b0;
        #2;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_k", 32'(bus.out_k), 32'd0);
        repeat (2) @(negedge pclk);
        #2 reset_n = 1'b1;
        idle(1);

        // Seed sequence after a COM
        send_exp(16'hBC00, 2'b10, 1'b0, 16'hBCFF);
        send_exp(16'h0000, 2'b00, 1'b0, 16'h17FF);
        send_exp(16'h0000, 2'b00, 1'b0, 16'h14C0);
        send_exp(16'h0000, 2'b00, 1'b0, 16'hE7B2);
        send_exp(16'h0000, 2'b00, 1'b0, 16'h8202);

        // COM in symbol 1 mid-stream reseeds
        send(16'hBC00, 2'b10, 1'b0);
        send_exp(16'h0000, 2'b00, 1'b0, 16'h17FF);

        // SKP handling
        send_exp(16'h1C1C, 2'b11, 1'b0, 16'h1C1C);
        send_exp(16'h001C, 2'b01, 1'b0, 16'hC01C);
        send_exp(16'h0000, 2'b00, 1'b0, 16'hB214);
        send_exp(16'h0000, 2'b00, 1'b0, 16'h02E7);

        // COM in symbol 0 with D in symbol 1
        send_exp(16'h00BC, 2'b01, 1'b0, 16'hFFBC);
        send_exp(16'h0000, 2'b00, 1'b0, 16'hC017);

        // Bypass still advances the LFSR
        send(16'hBC00, 2'b10, 1'b0);
        send_exp(16'h0000, 2'b00, 1'b1, 16'h0000);
        send_exp(16'h0000, 2'b00, 1'b0, 16'h14C0);

        // Idle gap resumes exactly
        idle(3);
        send_exp(16'h0000, 2'b00, 1'b0, 16'hE7B2);
        send_exp(16'h0000, 2'b00, 1'b0, 16'h8202);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 15) begin
                idle(1);
            end else begin
                rand_sym(d0, k0);
                rand_sym(d1, k1);
                send({d1, d0}, {k1, k0}, ($urandom_range(0, 9) == 0));
            end
        end

        // Asynchronous reset mid-stream, with a pair in flight
        send(16'h1234, 2'b00, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_data", 32'(bus.out_data), 32'd0);
        check("midrst_k", 32'(bus.out_k), 32'd0);
        q.delete();
        pos = 0;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge pclk);
        #2 reset_n = 1'b1;
        send_exp(16'h0000, 2'b00, 1'b0, 16'h17FF);
        send_exp(16'h0000, 2'b00, 1'b0, 16'h14C0);

        idle(4);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
